inner_inner_delay_unit: RTL and testbench

//   Two independent valid/ready channels, each a fixed-latency elastic delay

---
 rtl/inner_inner_delay_unit.sv | 93 +++++++++
 tb/tb_inner_inner_delay_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/inner_inner_delay_unit.sv
// Two independent fixed-latency elastic delay channels. Each channel is a chain
// of DEPTH valid/data stages whose advance is steered back from OUTPUT_<i>_ready.
module inner_inner_delay_unit #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] INPUT_0_data,
    input  logic             INPUT_0_valid,
    output logic             INPUT_0_ready,
    input  logic [WIDTH-1:0] INPUT_1_data,
    input  logic             INPUT_1_valid,
    output logic             INPUT_1_ready,
    output logic [WIDTH-1:0] OUTPUT_0_data,
    output logic             OUTPUT_0_valid,
    input  logic             OUTPUT_0_ready,
    output logic [WIDTH-1:0] OUTPUT_1_data,
    output logic             OUTPUT_1_valid,
    input  logic             OUTPUT_1_ready
);

    // Handshake: a beat moves across a port in any cycle where valid and ready
    // are both high; a producer keeps valid/data steady until that happens.
    logic [WIDTH-1:0] in_data  [2];
    logic [WIDTH-1:0] out_data [2];
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;

    assign in_data[0]   = INPUT_0_data;
    assign in_data[1]   = INPUT_1_data;
    assign in_valid     = {INPUT_1_valid, INPUT_0_valid};
    assign out_ready    = {OUTPUT_1_ready, OUTPUT_0_ready};

    assign INPUT_0_ready  = in_ready[0];
    assign INPUT_1_ready  = in_ready[1];
    assign OUTPUT_0_valid = out_valid[0];
    assign OUTPUT_1_valid = out_valid[1];
    assign OUTPUT_0_data  = out_data[0];
    assign OUTPUT_1_data  = out_data[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [DEPTH-1:0] stg_v;
        logic [WIDTH-1:0] stg_d [DEPTH];
        logic [DEPTH-1:0] load_ok;
        logic             accept;

        // A stage may load if it is empty or its contents move on this cycle;
        // walking from the output back lets bubbles collapse under a stall.
        always_comb begin
            logic go;
            go      = out_ready[ch];
            load_ok = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                go         = !stg_v[k] || go;
                load_ok[k] = go;
            end
        end

        assign in_ready[ch] = load_ok[0] & ~RESET;
        assign accept       = in_valid[ch] & in_ready[ch];

        always_ff @(posedge CLK) begin
            if (RESET) begin
                stg_v <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    stg_d[k] <= '0;
                end
            end else begin
                if (load_ok[0]) begin
                    stg_v[0] <= accept;
                    if (accept) begin
                        stg_d[0] <= in_data[ch];
                    end
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (load_ok[k]) begin
                        stg_v[k] <= stg_v[k-1];
                        if (stg_v[k-1]) begin
                            stg_d[k] <= stg_d[k-1];
                        end
                    end
                end
            end
        end

        assign out_valid[ch] = stg_v[DEPTH-1];
        assign out_data[ch]  = stg_d[DEPTH-1];
    end

endmodule

// File: tb/tb_inner_inner_delay_unit.sv
// Directed bench for inner_inner_delay_unit: a per-cycle vector table for the
// steady-state behaviour plus hand sequences for mid-stream reset and recovery.
module tb_inner_inner_delay_unit;

    localparam int WIDTH = 5;
    localparam int DEPTH = 3;

    logic             CLK;
    logic             RESET;
    logic [WIDTH-1:0] INPUT_0_data, INPUT_1_data, OUTPUT_0_data, OUTPUT_1_data;
    logic             INPUT_0_valid, INPUT_0_ready, INPUT_1_valid, INPUT_1_ready;
    logic             OUTPUT_0_valid, OUTPUT_0_ready, OUTPUT_1_valid, OUTPUT_1_ready;

    inner_inner_delay_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .INPUT_0_data(INPUT_0_data), .INPUT_0_valid(INPUT_0_valid), .INPUT_0_ready(INPUT_0_ready),
        .INPUT_1_data(INPUT_1_data), .INPUT_1_valid(INPUT_1_valid), .INPUT_1_ready(INPUT_1_ready),
        .OUTPUT_0_data(OUTPUT_0_data), .OUTPUT_0_valid(OUTPUT_0_valid), .OUTPUT_0_ready(OUTPUT_0_ready),
        .OUTPUT_1_data(OUTPUT_1_data), .OUTPUT_1_valid(OUTPUT_1_valid), .OUTPUT_1_ready(OUTPUT_1_ready)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic v0; logic [WIDTH-1:0] d0; logic or0;
        logic v1; logic [WIDTH-1:0] d1; logic or1;
        logic cd;
        logic ev0; logic [WIDTH-1:0] ed0; logic eir0;
        logic ev1; logic [WIDTH-1:0] ed1; logic eir1;
    } vec_t;

    vec_t             tbl[$];
    logic [WIDTH-1:0] exp_q[$];
    int               checks   = 0;
    int               failures = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic row(input logic v0, input logic [WIDTH-1:0] d0, input logic or0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic or1,
                       input logic cd,
                       input logic ev0, input logic [WIDTH-1:0] ed0, input logic eir0,
                       input logic ev1, input logic [WIDTH-1:0] ed1, input logic eir1);
        vec_t t;
        t.v0 = v0; t.d0 = d0; t.or0 = or0; t.v1 = v1; t.d1 = d1; t.or1 = or1; t.cd = cd;
        t.ev0 = ev0; t.ed0 = ed0; t.eir0 = eir0; t.ev1 = ev1; t.ed1 = ed1; t.eir1 = eir1;
        tbl.push_back(t);
    endtask

    // driver: set inputs at the falling edge, settle, leave sampling to caller
    task automatic drive(input logic rst,
                         input logic v0, input logic [WIDTH-1:0] d0, input logic or0,
                         input logic v1, input logic [WIDTH-1:0] d1, input logic or1);
        @(negedge CLK);
        RESET = rst;
        INPUT_0_valid = v0; INPUT_0_data = d0; OUTPUT_0_ready = or0;
        INPUT_1_valid = v1; INPUT_1_data = d1; OUTPUT_1_ready = or1;
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic with_data);
        chk({tag, "_ov0"}, {4'b0, OUTPUT_0_valid}, 5'd0);
        chk({tag, "_ov1"}, {4'b0, OUTPUT_1_valid}, 5'd0);
        if (with_data) begin
            chk({tag, "_od0"}, OUTPUT_0_data, 5'd0);
            chk({tag, "_od1"}, OUTPUT_1_data, 5'd0);
        end
    endtask

    initial begin
        RESET = 1'b1;
        INPUT_0_valid = 1'b0; INPUT_0_data = '0; OUTPUT_0_ready = 1'b1;
        INPUT_1_valid = 1'b0; INPUT_1_data = '0; OUTPUT_1_ready = 1'b1;
        repeat (2) @(posedge CLK);

        //   v0 d0     or0 v1 d1     or1 cd  ev0 ed0    ir0 ev1 ed1    ir1
        row(0, 5'h00, 1,  0, 5'h00, 1,  1,  0, 5'h00, 1,  0, 5'h00, 1);
        row(1, 5'h15, 1,  0, 5'h00, 1,  0,  0, 5'h00, 1,  0, 5'h00, 1);
        row(0, 5'h00, 1,  0, 5'h00, 1,  0,  0, 5'h00, 1,  0, 5'h00, 1);
        row(0, 5'h00, 1,  0, 5'h00, 1,  0,  0, 5'h00, 1,  0, 5'h00, 1);
        row(0, 5'h00, 1,  0, 5'h00, 1,  0,  1, 5'h15, 1,  0, 5'h00, 1);
        row(1, 5'h0A, 0,  1, 5'h01, 1,  0,  0, 5'h00, 1,  0, 5'h00, 1);
        row(1, 5'h0B, 0,  1, 5'h02, 1,  0,  0, 5'h00, 1,  0, 5'h00, 1);
        row(1, 5'h0C, 0,  1, 5'h03, 1,  0,  0, 5'h00, 1,  0, 5'h00, 1);
        row(1, 5'h0D, 0,  1, 5'h04, 1,  0,  1, 5'h0A, 0,  1, 5'h01, 1);
        row(1, 5'h0D, 1,  0, 5'h00, 1,  0,  1, 5'h0A, 1,  1, 5'h02, 1);
        row(0, 5'h00, 1,  0, 5'h00, 1,  0,  1, 5'h0B, 1,  1, 5'h03, 1);
        row(0, 5'h00, 0,  0, 5'h00, 1,  0,  1, 5'h0C, 1,  1, 5'h04, 1);
        row(0, 5'h00, 1,  1, 5'h1E, 0,  0,  1, 5'h0C, 1,  0, 5'h00, 1);
        row(0, 5'h00, 1,  0, 5'h00, 0,  0,  1, 5'h0D, 1,  0, 5'h00, 1);
        row(0, 5'h00, 1,  0, 5'h00, 0,  0,  0, 5'h00, 1,  0, 5'h00, 1);
        row(0, 5'h00, 1,  0, 5'h00, 0,  0,  0, 5'h00, 1,  1, 5'h1E, 1);
        row(0, 5'h00, 1,  0, 5'h00, 1,  0,  0, 5'h00, 1,  1, 5'h1E, 1);
        row(0, 5'h00, 1,  0, 5'h00, 1,  0,  0, 5'h00, 1,  0, 5'h00, 1);

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].v0, tbl[i].d0, tbl[i].or0, tbl[i].v1, tbl[i].d1, tbl[i].or1);
            chk($sformatf("row%0d_ov0", i), {4'b0, OUTPUT_0_valid}, {4'b0, tbl[i].ev0});
            chk($sformatf("row%0d_ir0", i), {4'b0, INPUT_0_ready},  {4'b0, tbl[i].eir0});
            chk($sformatf("row%0d_ov1", i), {4'b0, OUTPUT_1_valid}, {4'b0, tbl[i].ev1});
            chk($sformatf("row%0d_ir1", i), {4'b0, INPUT_1_ready},  {4'b0, tbl[i].eir1});
            if (tbl[i].ev0 || tbl[i].cd) chk($sformatf("row%0d_od0", i), OUTPUT_0_data, tbl[i].ed0);
            if (tbl[i].ev1 || tbl[i].cd) chk($sformatf("row%0d_od1", i), OUTPUT_1_data, tbl[i].ed1);
        end

        // reset with beats in flight on both channels
        drive(1'b0, 1'b1, 5'h11, 1'b1, 1'b1, 5'h13, 1'b1);
        chk("rst_pre_ir0", {4'b0, INPUT_0_ready}, 5'd1);
        drive(1'b0, 1'b1, 5'h12, 1'b1, 1'b0, 5'h00, 1'b1);
        drive(1'b1, 1'b1, 5'h14, 1'b1, 1'b1, 5'h16, 1'b1);
        chk("rst_ir0", {4'b0, INPUT_0_ready}, 5'd0);
        chk("rst_ir1", {4'b0, INPUT_1_ready}, 5'd0);
        drive(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b1);
        chk_idle("post_rst", 1'b1);
        chk("post_rst_ir0", {4'b0, INPUT_0_ready}, 5'd1);
        chk("post_rst_ir1", {4'b0, INPUT_1_ready}, 5'd1);
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b1);
            chk_idle($sformatf("flush%0d", n), 1'b1);
        end

        // recovery: a fresh burst on channel 0 drains in order
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b1, 5'(7 + n), 1'b1, 1'b0, 5'h00, 1'b1);
            chk($sformatf("rec_ir0_%0d", n), {4'b0, INPUT_0_ready}, 5'd1);
            exp_q.push_back(5'(7 + n));
        end
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
            drive(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b1);
            if (OUTPUT_0_valid) chk("rec_od0", OUTPUT_0_data, exp_q.pop_front());
            chk("rec_ov1", {4'b0, OUTPUT_1_valid}, 5'd0);
        end
        chk("rec_left", 5'(exp_q.size()), 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
